// File: rtl/butterfly_feeder_if.sv
// Sample type and the stream bundle between the host, the feeder and butterfly_8.
// master = host/consumer side, slave = feeder side.
package butterfly_feeder_pkg;
    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
    } complex_number_t;
endpackage

interface butterfly_feeder_if #(
    parameter int LOG_N   = 3,
    parameter int STAGE_W = 2
);
    import butterfly_feeder_pkg::*;

    complex_number_t      in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [STAGE_W-1:0]   stage;
    complex_number_t      op_a;
    complex_number_t      op_b;
    logic [LOG_N-2:0]     twiddle_idx;
    logic                 op_valid;
    logic                 op_ready;
    logic                 frame_done;

    modport master (
        output in_data, in_valid, stage, op_ready,
        input  in_ready, op_a, op_b, twiddle_idx, op_valid, frame_done
    );

    modport slave (
        input  in_data, in_valid, stage, op_ready,
        output in_ready, op_a, op_b, twiddle_idx, op_valid, frame_done
    );
endinterface

// File: rtl/butterfly_feeder.sv
// Buffers one N-sample frame, then issues the N/2 radix-2 DIF operand pairs
// and twiddle indices for the host-selected stage.
module butterfly_feeder #(
    parameter int LOG_N   = 3,
    parameter int STAGE_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    butterfly_feeder_if.slave bus,
    output logic [0:0]       dbg_state
);
    import butterfly_feeder_pkg::*;

    localparam int N    = 1 << LOG_N;
    localparam int HALF = N / 2;
    localparam int KW   = LOG_N - 1;

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(LOG_N - 1);
    localparam logic [LOG_N:0]     N_FULL    = (LOG_N + 1)'(N);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid never depends combinationally on ready and
    // the offered payload is held unchanged until that transfer.

    logic [0:0]         state;
    logic [LOG_N-1:0]   wr_cnt;
    logic [KW-1:0]      k;
    logic [STAGE_W-1:0] stage_q;
    logic               frame_done_q;
    complex_number_t    sample_buf [N];

    logic [STAGE_W-1:0] stage_clamped;
    logic [STAGE_W:0]   shamt;
    logic [LOG_N:0]     span_full;
    logic [LOG_N-1:0]   span;
    logic [LOG_N-1:0]   k_ext;
    logic [LOG_N-1:0]   pos;
    logic [LOG_N-1:0]   idx_a;
    logic [LOG_N-1:0]   idx_b;
    logic [LOG_N-1:0]   tw_full;

    assign stage_clamped = (bus.stage > STAGE_MAX) ? STAGE_MAX : bus.stage;

    // span is a power of two, so pos = k mod span is a mask and
    // grp*2*span = 2*(k - pos).
    always_comb begin
        shamt     = {1'b0, stage_q} + (STAGE_W + 1)'(1);
        span_full = N_FULL >> shamt;
        span      = span_full[LOG_N-1:0];
        k_ext     = {1'b0, k};
        pos       = k_ext & (span - LOG_N'(1));
        idx_a     = ((k_ext - pos) << 1) + pos;
        idx_b     = idx_a + span;
        tw_full   = pos << stage_q;
    end

    assign bus.op_a        = sample_buf[idx_a];
    assign bus.op_b        = sample_buf[idx_b];
    assign bus.twiddle_idx = tw_full[KW-1:0];
    assign bus.op_valid    = (state == ST_ISSUE);
    assign bus.in_ready    = (state == ST_LOAD);
    assign bus.frame_done  = frame_done_q;
    assign dbg_state       = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_LOAD;
            wr_cnt       <= '0;
            k            <= '0;
            stage_q      <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sample_buf[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        sample_buf[wr_cnt] <= bus.in_data;
                        if (wr_cnt == LOG_N'(N - 1)) begin
                            stage_q <= stage_clamped;
                            wr_cnt  <= '0;
                            k       <= '0;
                            state   <= ST_ISSUE;
                        end else begin
                            wr_cnt <= wr_cnt + LOG_N'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.op_ready) begin
                        if (k == KW'(HALF - 1)) begin
                            k            <= '0;
                            state        <= ST_LOAD;
                            frame_done_q <= 1'b1;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_butterfly_feeder.sv
// Bench for butterfly_feeder: directed frames plus randomized frames, checked
// against a butterfly-group reference model.
module tb_butterfly_feeder;
  import butterfly_feeder_pkg::*;

  localparam int LOG_N   = 3;
  localparam int STAGE_W = 2;
  localparam int N       = 1 << LOG_N;
  localparam int HALF    = N / 2;
  localparam int TW_W    = LOG_N - 1;
  localparam int W       = 32 + TW_W;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] dbg_state;

  always #5 clock = ~clock;

  butterfly_feeder_if #(.LOG_N(LOG_N), .STAGE_W(STAGE_W)) bus();

  butterfly_feeder #(.LOG_N(LOG_N), .STAGE_W(STAGE_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  complex_number_t frame [N];
  logic [W-1:0]    exp_q [$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  // Stage s splits the frame into groups of 2*span; each group pairs
  // element p with element p+span and uses twiddle p*2^s.
  task automatic build_expected(input int stage);
    int s, span;
    s    = (stage > LOG_N - 1) ? LOG_N - 1 : stage;
    span = N >> (s + 1);
    for (int g = 0; g < N; g += 2 * span) begin
      for (int p = 0; p < span; p++) begin
        exp_q.push_back({frame[g + p], frame[g + p + span], TW_W'(p << s)});
      end
    end
  endtask

  task automatic fill_frame(input bit random_data);
    for (int i = 0; i < N; i++) begin
      if (random_data) frame[i] = complex_number_t'(16'($urandom));
      else             frame[i] = '{re: 8'(i), im: 8'(100 + i)};
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_state", dbg_state, 0);
    check("rst_outputs", {bus.op_a, bus.op_b, bus.twiddle_idx}, 0);
    exp_q.delete();
  endtask

  // gap_mode: 0 = valid every cycle, 1 = valid toggles 1,0,1,..., 2 = random
  task automatic load_frame(input int stage, input int n_samples, input int gap_mode);
    int idx, cyc;
    bit v;
    idx = 0;
    cyc = 0;
    bus.stage = STAGE_W'(stage);
    while (idx < n_samples && cyc < 200) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? frame[idx] : complex_number_t'(16'hA55A);
      check("load_in_ready", bus.in_ready, 1);
      check("load_op_valid", bus.op_valid, 0);
      if (v) idx++;
      cyc++;
      tick();
    end
    bus.in_valid = 1'b0;
    if (idx < n_samples) check("load_timeout", idx, n_samples);
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = stall 3 cycles on pair 1
  task automatic collect_pairs(input int ready_mode, input int max_pairs, input bit junk_valid);
    int popped, cyc, stalls;
    bit r;
    popped = 0;
    cyc    = 0;
    stalls = 0;
    while (popped < max_pairs && exp_q.size() > 0 && cyc < 400) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          r = !(popped == 1 && stalls < 3);
          if (!r) stalls++;
        end
      endcase
      bus.op_ready = r;
      bus.in_valid = junk_valid;
      bus.in_data  = complex_number_t'(16'hFFFF);
      check("issue_op_valid", bus.op_valid, 1);
      check("issue_in_ready", bus.in_ready, 0);
      check("issue_frame_done", bus.frame_done, 0);
      check("pair", {bus.op_a, bus.op_b, bus.twiddle_idx}, exp_q[0]);
      if (r) begin
        void'(exp_q.pop_front());
        popped++;
      end
      cyc++;
      tick();
    end
    bus.op_ready = 1'b0;
    bus.in_valid = 1'b0;
    if (popped < max_pairs) check("issue_timeout", popped, max_pairs);
  endtask

  // Called on the cycle after the last pair handshake.
  task automatic check_done(input bit back_to_back);
    check("done_pulse", bus.frame_done, 1);
    check("done_in_ready", bus.in_ready, 1);
    check("done_op_valid", bus.op_valid, 0);
    if (!back_to_back) begin
      tick();
      check("done_single", bus.frame_done, 0);
    end
  endtask

  task automatic run_frame(input int stage, input int gap_mode, input int ready_mode,
                           input bit junk_valid, input bit back_to_back);
    load_frame(stage, N, gap_mode);
    build_expected(stage);
    collect_pairs(ready_mode, HALF, junk_valid);
    check_done(back_to_back);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.stage    = '0;
    bus.op_ready = 1'b0;
    tick();
    do_reset();

    // ramp frame through every stage, including the clamped one
    for (int s = 0; s <= 3; s++) begin
      fill_frame(1'b0);
      run_frame(s, 0, 0, 1'b0, 1'b0);
    end

    // downstream stall on pair 1
    fill_frame(1'b0);
    run_frame(0, 0, 2, 1'b0, 1'b0);

    // gapped load, junk offered while issuing
    fill_frame(1'b1);
    run_frame(1, 1, 0, 1'b1, 1'b0);

    // reset after 5 samples, then a clean frame
    fill_frame(1'b1);
    load_frame(0, 5, 0);
    do_reset();
    fill_frame(1'b0);
    run_frame(0, 0, 0, 1'b0, 1'b0);

    // reset after pair k=2 has been taken, then a fresh frame
    fill_frame(1'b1);
    load_frame(2, N, 0);
    build_expected(2);
    collect_pairs(0, 3, 1'b0);
    check("mid_issue_state", dbg_state, 1);
    do_reset();
    fill_frame(1'b1);
    run_frame(1, 0, 0, 1'b0, 1'b0);

    // back-to-back: second frame starts on the frame_done cycle
    fill_frame(1'b0);
    run_frame(0, 0, 0, 1'b0, 1'b1);
    fill_frame(1'b1);
    run_frame(1, 0, 1, 1'b0, 1'b0);

    // randomized frames
    for (int it = 0; it < 12; it++) begin
      fill_frame(1'b1);
      run_frame($urandom_range(0, 3), 2, 1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
